// File: rtl/wishbone_interconnect_nport_pkg.sv
// Shared types, register offsets and address decode for the N-port Wishbone interconnect.
package wishbone_interconnect_nport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLAVE,
        ST_INT,
        ST_ERR,
        ST_DONE
    } wb_state_e;

    typedef enum logic [1:0] {
        TGT_SLAVE,
        TGT_INT,
        TGT_UNMAPPED
    } wb_target_e;

    localparam logic [7:0] INT_ADDR_DEFAULT = 8'hFF;

    // Interrupt block registers are selected by m_adr_i[2].
    localparam logic INT_REG_PENDING = 1'b0;
    localparam logic INT_REG_MASK    = 1'b1;

    function automatic wb_target_e decode_sel(input logic [7:0] sel,
                                              input int         num_slaves,
                                              input logic [7:0] int_addr);
        if (int'(sel) < num_slaves) return TGT_SLAVE;
        if (sel == int_addr)        return TGT_INT;
        return TGT_UNMAPPED;
    endfunction

endpackage

// File: rtl/wishbone_interconnect_nport_if.sv
// Bus bundle between the host master, the interconnect and the peripheral slaves.
// Signal suffixes are relative to the interconnect; 'slave' is the interconnect's own view.
interface wishbone_interconnect_nport_if #(
    parameter int NUM_SLAVES = 4
);
    logic                       m_we_i;
    logic                       m_cyc_i;
    logic                       m_stb_i;
    logic [3:0]                 m_sel_i;
    logic [31:0]                m_adr_i;
    logic [31:0]                m_dat_i;
    logic [31:0]                m_dat_o;
    logic                       m_ack_o;
    logic                       m_err_o;
    logic                       m_int_o;
    logic                       s_we_o;
    logic [3:0]                 s_sel_o;
    logic [31:0]                s_adr_o;
    logic [31:0]                s_dat_o;
    logic [NUM_SLAVES-1:0]      s_cyc_o;
    logic [NUM_SLAVES-1:0]      s_stb_o;
    logic [32*NUM_SLAVES-1:0]   s_dat_i;
    logic [NUM_SLAVES-1:0]      s_ack_i;
    logic [NUM_SLAVES-1:0]      s_int_i;

    modport slave (
        input  m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_int_i,
        output m_dat_o, m_ack_o, m_err_o, m_int_o,
        output s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_int_i,
        input  m_dat_o, m_ack_o, m_err_o, m_int_o,
        input  s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wishbone_interconnect_nport_int_ctrl.sv
// Interrupt block: sticky pending bits with W1C, mask register and registered interrupt output.
module wishbone_interconnect_nport_int_ctrl
    import wishbone_interconnect_nport_pkg::*;
#(
    parameter int          NUM_SLAVES   = 4,
    parameter logic [31:0] INT_MASK_RST = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic                  reg_sel_i,
    input  logic [31:0]           wdata_i,
    input  logic [NUM_SLAVES-1:0] s_int_i,
    output logic [31:0]           rdata_o,
    output logic                  int_o
);
    logic [31:0] pending_q, pending_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] w1c;
    logic        int_q;

    // Clear is applied before the OR, so a source held high wins over a same-cycle W1C.
    always_comb begin
        w1c       = (wr_en_i && reg_sel_i == INT_REG_PENDING) ? wdata_i : '0;
        pending_d = (pending_q & ~w1c) | 32'(s_int_i);
        mask_d    = (wr_en_i && reg_sel_i == INT_REG_MASK) ? wdata_i : mask_q;
    end

    // NOTE: every state register here is reset explicitly; the mask must come up at
    // INT_MASK_RST, not at zero, so no register is left to power-up values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            mask_q    <= INT_MASK_RST;
            int_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pending_q <= pending_d;
            mask_q    <= mask_d;
            int_q     <= |(pending_q & mask_q);
        end
    end

    assign rdata_o = (reg_sel_i == INT_REG_MASK) ? mask_q : (pending_q & mask_q);
    assign int_o   = int_q;

endmodule

// File: rtl/wishbone_interconnect_nport.sv
// Single-master, NUM_SLAVES-slave Wishbone classic interconnect with watchdog timeout,
// unmapped-address bus error and an internal interrupt block.
module wishbone_interconnect_nport
    import wishbone_interconnect_nport_pkg::*;
#(
    parameter int          NUM_SLAVES   = 4,
    parameter int          TIMEOUT      = 1024,
    parameter logic [7:0]  INT_ADDR     = INT_ADDR_DEFAULT,
    parameter logic [31:0] INT_MASK_RST = 32'hFFFF_FFFF
) (
    input logic clk,
    input logic rst,
    wishbone_interconnect_nport_if.slave bus
);
    localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT);

    wb_state_e            state_q, state_d;
    wb_target_e           target;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [31:0]          m_dat_q, m_dat_d;
    logic                 m_ack_q, m_ack_d;
    logic                 m_err_q, m_err_d;
    logic                 in_slave;
    logic                 slave_ack;
    logic [31:0]          slave_rdata;
    logic [31:0]          int_rdata;
    logic                 int_wr;
    logic                 int_irq;
    logic [NUM_SLAVES-1:0] cyc_vec, stb_vec;

    assign target      = decode_sel(bus.m_adr_i[31:24], NUM_SLAVES, INT_ADDR);
    assign in_slave    = (state_q == ST_SLAVE);
    assign slave_ack   = bus.s_ack_i[idx_q];
    assign slave_rdata = bus.s_dat_i[32*int'(idx_q) +: 32];
    assign int_wr      = (state_q == ST_INT) && bus.m_cyc_i && bus.m_we_i;

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = '0;
        m_dat_d = m_dat_q;
        m_ack_d = 1'b0;
        m_err_d = 1'b0;
        if (!bus.m_cyc_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.m_stb_i) begin
                    idx_d = bus.m_adr_i[24 +: IDX_W];
                    case (target)
                        TGT_SLAVE: state_d = ST_SLAVE;
                        TGT_INT:   state_d = ST_INT;
                        default:   state_d = ST_ERR;
                    endcase
                end
                ST_SLAVE: begin
                    // An ack arriving on the final timeout cycle still completes normally.
                    if (slave_ack) begin
                        m_dat_d = slave_rdata;
                        m_ack_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                        m_err_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_INT: begin
                    m_dat_d = int_rdata;
                    m_ack_d = 1'b1;
                    state_d = ST_DONE;
                end
                ST_ERR: begin
                    m_dat_d = '0;
                    m_err_d = 1'b1;
                    state_d = ST_DONE;
                end
                ST_DONE: if (!bus.m_stb_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            m_dat_q <= '0;
            m_ack_q <= 1'b0;
            m_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            m_dat_q <= m_dat_d;
            m_ack_q <= m_ack_d;
            m_err_q <= m_err_d;
        end
    end

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_strobe
        assign cyc_vec[k] = in_slave && (idx_q == IDX_W'(k)) && bus.m_cyc_i;
        assign stb_vec[k] = in_slave && (idx_q == IDX_W'(k)) && bus.m_stb_i;
    end

    assign bus.s_cyc_o = cyc_vec;
    assign bus.s_stb_o = stb_vec;
    assign bus.s_we_o  = in_slave && bus.m_we_i;
    assign bus.s_sel_o = in_slave ? bus.m_sel_i : '0;
    assign bus.s_adr_o = in_slave ? {8'h00, bus.m_adr_i[23:0]} : '0;
    assign bus.s_dat_o = in_slave ? bus.m_dat_i : '0;

    assign bus.m_dat_o = m_dat_q;
    assign bus.m_ack_o = m_ack_q;
    assign bus.m_err_o = m_err_q;
    assign bus.m_int_o = int_irq;

    wishbone_interconnect_nport_int_ctrl #(
        .NUM_SLAVES   (NUM_SLAVES),
        .INT_MASK_RST (INT_MASK_RST)
    ) u_int_ctrl (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (int_wr),
        .reg_sel_i (bus.m_adr_i[2]),
        .wdata_i   (bus.m_dat_i),
        .s_int_i   (bus.s_int_i),
        .rdata_o   (int_rdata),
        .int_o     (int_irq)
    );

endmodule

// File: tb/tb_wishbone_interconnect_nport.sv
// Directed bench for wishbone_interconnect_nport: a vector table of single accesses plus
// hand-written sequences for held strobe, abort, interrupts and mid-transaction reset.
module tb_wishbone_interconnect_nport;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam int NV = 10;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          slave;   // slave that answers, -1 for internal/unmapped
        int          delay;   // negedge index at which the slave acks, -1 never
        logic [31:0] sdat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_lat; // negedges from strobe to m_ack_o/m_err_o
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[NV];

    wishbone_interconnect_nport_if #(.NUM_SLAVES(NS)) bus ();

    wishbone_interconnect_nport #(
        .NUM_SLAVES   (NS),
        .TIMEOUT      (TO),
        .INT_ADDR     (8'hFF),
        .INT_MASK_RST (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat);
        @(negedge clk);
        bus.m_we_i  = we;
        bus.m_adr_i = adr;
        bus.m_dat_i = wdat;
        bus.m_sel_i = 4'hF;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
    endtask

    // Plays the addressed slave and waits (bounded) for m_ack_o or m_err_o.
    task automatic wait_done(input int slave, input int delay, input logic [31:0] sdat,
                             output logic ack, output logic err, output logic [31:0] dat,
                             output int lat, output logic [NS-1:0] stb1,
                             output logic [31:0] adr1, output logic stray);
        logic [NS-1:0] allowed;
        allowed = (slave >= 0) ? NS'(1 << slave) : '0;
        ack = 0; err = 0; dat = '0; lat = 0; stb1 = '0; adr1 = '0; stray = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.s_ack_i = '0;
            if (c == 1) begin
                stb1 = bus.s_stb_o;
                adr1 = bus.s_adr_o;
            end
            if ((bus.s_stb_o & ~allowed) != '0) stray = 1;
            if (bus.m_ack_o || bus.m_err_o) begin
                ack = bus.m_ack_o;
                err = bus.m_err_o;
                dat = bus.m_dat_o;
                lat = c;
                break;
            end
            if (slave >= 0 && c == delay) begin
                bus.s_ack_i[slave]           = 1'b1;
                bus.s_dat_i[32*slave +: 32]  = sdat;
            end
        end
    endtask

    task automatic end_access();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_we_i  = 1'b0;
        bus.s_ack_i = '0;
        @(negedge clk);
    endtask

    task automatic int_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                              output logic ack, output logic [31:0] dat);
        logic err, stray;
        logic [NS-1:0] stb1;
        logic [31:0] adr1;
        int lat;
        start_access(we, adr, wdat);
        wait_done(-1, -1, 32'h0, ack, err, dat, lat, stb1, adr1, stray);
        end_access();
    endtask

    initial begin
        logic        ack, err, stray;
        logic [31:0] dat, adr1, exp_adr;
        logic [NS-1:0] stb1, exp_stb;
        int          lat, evt;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"rd_s2",      1'b0, 32'h0200_0010, 32'h0,         2,  3, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 4};
        vecs[1] = '{"wr_s0",      1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 0,  1, 32'h1111_2222, 1'b1, 1'b0, 32'h1111_2222, 2};
        vecs[2] = '{"rd_s3",      1'b0, 32'h0300_00FC, 32'h0,         3,  5, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 6};
        vecs[3] = '{"timeout_s1", 1'b0, 32'h0100_0000, 32'h0,         1, -1, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 9};
        vecs[4] = '{"ack_at_to",  1'b0, 32'h0100_0020, 32'h0,         1,  8, 32'h0BAD_C0DE, 1'b1, 1'b0, 32'h0BAD_C0DE, 9};
        vecs[5] = '{"unmap_07",   1'b0, 32'h0700_0000, 32'h0,        -1, -1, 32'h0,         1'b0, 1'b1, 32'h0,         2};
        vecs[6] = '{"unmap_04",   1'b1, 32'h0400_0000, 32'h1,        -1, -1, 32'h0,         1'b0, 1'b1, 32'h0,         2};
        vecs[7] = '{"unmap_fe",   1'b0, 32'hFE00_0000, 32'h0,        -1, -1, 32'h0,         1'b0, 1'b1, 32'h0,         2};
        vecs[8] = '{"int_mask",   1'b0, 32'hFF00_0004, 32'h0,        -1, -1, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 2};
        vecs[9] = '{"int_pend",   1'b0, 32'hFF00_0000, 32'h0,        -1, -1, 32'h0,         1'b1, 1'b0, 32'h0,         2};

        rst         = 1'b0;
        bus.m_we_i  = 1'b0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_sel_i = 4'h0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = '0;
        bus.s_int_i = '0;

        repeat (3) @(negedge clk);
        check("reset_m_dat", bus.m_dat_o, 32'h0);
        check("reset_m_flags", 32'({bus.m_ack_o, bus.m_err_o, bus.m_int_o}), 32'h0);
        check("reset_s_strobes", 32'({bus.s_cyc_o, bus.s_stb_o}), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            start_access(vecs[i].we, vecs[i].adr, vecs[i].wdat);
            wait_done(vecs[i].slave, vecs[i].delay, vecs[i].sdat, ack, err, dat, lat, stb1, adr1, stray);
            exp_stb = (vecs[i].slave >= 0) ? NS'(1 << vecs[i].slave) : '0;
            exp_adr = (vecs[i].slave >= 0) ? {8'h00, vecs[i].adr[23:0]} : 32'h0;
            check({vecs[i].name, "_ack"}, 32'(ack), 32'(vecs[i].exp_ack));
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_dat"}, dat, vecs[i].exp_dat);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_stb1"}, 32'(stb1), 32'(exp_stb));
            check({vecs[i].name, "_s_adr"}, adr1, exp_adr);
            check({vecs[i].name, "_stray_stb"}, 32'(stray), 32'h0);
            check({vecs[i].name, "_done_strobes"}, 32'({bus.s_cyc_o, bus.s_stb_o}), 32'h0);
            end_access();
            check({vecs[i].name, "_single_cycle"}, 32'({bus.m_ack_o, bus.m_err_o}), 32'h0);
        end

        // Held strobe after completion must not start a second access.
        start_access(1'b0, 32'h0000_0008, 32'h0);
        wait_done(0, 2, 32'h5555_AAAA, ack, err, dat, lat, stb1, adr1, stray);
        check("hold_first_ack", 32'({ack, err}), 32'h2);
        check("hold_first_lat", 32'(lat), 32'd3);
        evt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.m_ack_o || bus.m_err_o || (|bus.s_stb_o)) evt++;
        end
        check("hold_no_retrigger", 32'(evt), 32'h0);
        bus.m_stb_i = 1'b0;
        @(negedge clk);
        bus.m_adr_i = 32'h0200_0000;
        bus.m_stb_i = 1'b1;
        wait_done(2, 1, 32'h2222_3333, ack, err, dat, lat, stb1, adr1, stray);
        check("restrobe_ack", 32'({ack, err}), 32'h2);
        check("restrobe_dat", dat, 32'h2222_3333);
        end_access();

        // Abort in SLAVE with a coincident slave ack: no response, data held.
        start_access(1'b0, 32'h0200_0000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_stb_before", 32'(bus.s_stb_o), 32'h4);
        bus.m_cyc_i        = 1'b0;
        bus.m_stb_i        = 1'b0;
        bus.s_ack_i[2]     = 1'b1;
        bus.s_dat_i[64 +: 32] = 32'hFFFF_0000;
        evt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.s_ack_i = '0;
            if (bus.m_ack_o || bus.m_err_o) evt++;
        end
        check("abort_no_resp", 32'(evt), 32'h0);
        check("abort_dat_held", bus.m_dat_o, 32'h2222_3333);
        start_access(1'b0, 32'h0300_0000, 32'h0);
        wait_done(3, 2, 32'h3C3C_3C3C, ack, err, dat, lat, stb1, adr1, stray);
        check("post_abort_ack", 32'({ack, err}), 32'h2);
        check("post_abort_dat", dat, 32'h3C3C_3C3C);
        end_access();

        // Sticky pending, W1C, and set-wins-over-clear.
        @(negedge clk);
        bus.s_int_i = 4'b1000;
        @(negedge clk);
        bus.s_int_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("irq3_m_int", 32'(bus.m_int_o), 32'h1);
        int_access(1'b0, 32'hFF00_0000, 32'h0, ack, dat);
        check("irq3_pending_rd", dat, 32'h8);
        int_access(1'b1, 32'hFF00_0000, 32'h8, ack, dat);
        check("w1c_ack", 32'(ack), 32'h1);
        check("w1c_m_int", 32'(bus.m_int_o), 32'h0);
        int_access(1'b0, 32'hFF00_0000, 32'h0, ack, dat);
        check("w1c_pending_rd", dat, 32'h0);
        bus.s_int_i = 4'b1000;
        @(negedge clk);
        int_access(1'b1, 32'hFF00_0000, 32'h8, ack, dat);
        bus.s_int_i = '0;
        int_access(1'b0, 32'hFF00_0000, 32'h0, ack, dat);
        check("set_wins_pending", dat, 32'h8);
        check("set_wins_m_int", 32'(bus.m_int_o), 32'h1);

        // Mask all, then raise slave 0: nothing visible.
        int_access(1'b1, 32'hFF00_0004, 32'h0, ack, dat);
        bus.s_int_i = 4'b0001;
        @(negedge clk);
        bus.s_int_i = '0;
        repeat (3) @(negedge clk);
        check("masked_m_int", 32'(bus.m_int_o), 32'h0);
        int_access(1'b0, 32'hFF00_0000, 32'h0, ack, dat);
        check("masked_pending_rd", dat, 32'h0);
        int_access(1'b0, 32'hFF00_0004, 32'h0, ack, dat);
        check("mask_rd_zero", dat, 32'h0);
        int_access(1'b1, 32'hFF00_0004, 32'hFFFF_FFFF, ack, dat);
        @(negedge clk);
        check("unmask_m_int", 32'(bus.m_int_o), 32'h1);
        int_access(1'b0, 32'hFF00_0000, 32'h0, ack, dat);
        check("unmask_pending_rd", dat, 32'h9);

        // Asynchronous reset in the middle of a slave write.
        start_access(1'b1, 32'h0100_0040, 32'h1234_5678);
        @(negedge clk);
        check("rst_pre_we", 32'(bus.s_we_o), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rst_m_dat", bus.m_dat_o, 32'h0);
        check("rst_m_flags", 32'({bus.m_ack_o, bus.m_err_o, bus.m_int_o}), 32'h0);
        check("rst_s_strobes", 32'({bus.s_cyc_o, bus.s_stb_o}), 32'h0);
        check("rst_s_we_sel", 32'({bus.s_we_o, bus.s_sel_o}), 32'h0);
        check("rst_s_adr", bus.s_adr_o, 32'h0);
        check("rst_s_dat", bus.s_dat_o, 32'h0);
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_we_i  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        int_access(1'b0, 32'hFF00_0004, 32'h0, ack, dat);
        check("rst_mask_rd", dat, 32'hFFFF_FFFF);
        int_access(1'b0, 32'hFF00_0000, 32'h0, ack, dat);
        check("rst_pending_rd", dat, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
